// File: rtl/popcnt_pkg.sv
// ============================================================================
// popcnt_pkg : shared constants, state encoding and width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package popcnt_pkg;

  localparam int CHUNK_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/popcnt6.sv
// ============================================================================
// popcnt6 : combinational ones count of a 6-bit chunk (result 0..6)
// Rev 1.0
// ============================================================================
`default_nettype none

module popcnt6 (
  input  logic [5:0] in_bits,
  output logic [2:0] count
);

  assign count = 3'(in_bits[0]) + 3'(in_bits[1]) + 3'(in_bits[2])
               + 3'(in_bits[3]) + 3'(in_bits[4]) + 3'(in_bits[5]);

endmodule

`default_nettype wire

// File: rtl/popcnt_seq.sv
// ============================================================================
// popcnt_seq : multi-cycle popcount of a W-bit word, one 6-bit chunk per cycle
// Optional macro POPCNT_EARLY_EXIT_EN stops RUN once the remaining chunks are 0.
// Rev 1.0
// ============================================================================
`default_nettype none

module popcnt_seq
  import popcnt_pkg::*;
#(
  parameter int W      = 24,
  parameter int NCHUNK = W / CHUNK_W,
  parameter int CW     = cnt_w(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          busy
);

  localparam int              IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  state_t            state;
  logic [W-1:0]      sreg;
  logic [CW-1:0]     acc;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        chunk_cnt;
  logic [CW-1:0]     sum;
  logic              last;

  // Single shared ones counter always looks at the low chunk of the shifter.
  popcnt6 u_popcnt6 (
    .in_bits (sreg[CHUNK_W-1:0]),
    .count   (chunk_cnt)
  );

  assign sum = acc + CW'(chunk_cnt);

`ifdef POPCNT_EARLY_EXIT_EN
  assign last = (idx == IDX_LAST) || ((sreg >> CHUNK_W) == '0);
`else
  assign last = (idx == IDX_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      acc       <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_count <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sreg     <= in_data;
            acc      <= '0;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc  <= sum;
          sreg <= sreg >> CHUNK_W;
          idx  <= idx + IDX_W'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_count <= sum;
          end
        end
        DONE: begin
          // in_ready stays low here so a word is never taken alongside the result
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_count <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_popcnt_seq.sv
// ============================================================================
// tb_popcnt_seq : directed self-checking bench for popcnt_seq (W=24)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_popcnt_seq;

  localparam int W  = 24;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          busy;

  int vectors = 0;
  int errors  = 0;

  popcnt_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a word, count RUN cycles until out_valid, check count, then handshake.
  task automatic run_word(input string tag, input logic [W-1:0] data,
                          input int exp_cnt, input int exp_lat);
    int n;
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_cnt"}, 32'(out_count), 32'(exp_cnt));
    chk({tag, "_inrdy_done"}, 32'(in_ready), 32'd0);
    tick();
    chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
    chk({tag, "_inrdy_idle"}, 32'(in_ready), 32'd1);
    chk({tag, "_cnt_idle"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    int n;
    int lat_zero, lat_3f, lat_ff00;
`ifdef POPCNT_EARLY_EXIT_EN
    lat_zero = 1; lat_3f = 1; lat_ff00 = 3;
`else
    lat_zero = 4; lat_3f = 4; lat_ff00 = 4;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;

    run_word("zero",  24'h000000, 0,  lat_zero);
    run_word("ones",  24'hFFFFFF, 24, 4);
    run_word("a5",    24'hA5A5A5, 12, 4);
    run_word("edges", 24'h800001, 2,  4);
    run_word("low3f", 24'h00003F, 6,  lat_3f);

    // Backpressure with in_valid held high and different data offered.
    out_ready = 1'b0;
    in_data   = 24'h00FF00;
    in_valid  = 1'b1;
    tick();
    in_data = 24'hFFFFFF;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_lat", 32'(n), 32'(lat_ff00));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_cnt",   32'(out_count), 32'd8);
      chk("bp_hold_inrdy", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_inrdy", 32'(in_ready),  32'd1);
    chk("bp_release_busy",  32'(busy),      32'd0);
    in_valid = 1'b0;
    tick();
    chk("bp_no_capture", 32'(busy), 32'd0);

    // Reset during the second RUN cycle.
    in_data  = 24'hFFFFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_count", 32'(out_count), 32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    tick();
    rst_n = 1'b1;
    run_word("post_rst", 24'h800001, 2, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/popcnt_seq.md
Name: popcnt_seq

Overview:
- Multi-cycle population-count controller for words wider than the 6-bit ones-counter datapath.
- Accepts a W-bit word over a valid/ready handshake and feeds it through one shared 6-bit popcount unit, one chunk per cycle.
- Accumulates the per-chunk counts and presents the total over an output valid/ready handshake.
- Sits between a producer of wide words (e.g. a register file or bus slave) and any consumer of the count.

Parameters:
- W, 24, input word width; must be a multiple of 6 and at least 6.
- NCHUNK, W/6, number of 6-bit chunks (derived; do not override).
- CW, $clog2(W+1), width of the count result.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block can accept a word.
- in_data  input  W  word to count.
- out_valid  output  1  out_count is valid.
- out_ready  input  1  consumer accepts the result.
- out_count  output  CW  number of 1 bits in the accepted word.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, shift register=0, acc=0, idx=0, in_ready=1, out_valid=0, out_count=0, busy=0.
  - Reset mid-RUN or mid-DONE aborts the operation with no output.
  - The first accept is possible on the first rising edge after rst_n is released.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: sreg<=in_data, acc<=0, idx<=0, go to RUN.
- RUN, one cycle per chunk:
  - acc <= acc + popcnt6(sreg[5:0]); sreg <= sreg>>6; idx <= idx+1.
  - When idx==NCHUNK-1, go to DONE after that final add.
  - in_ready=0.
- DONE:
  - out_valid=1 and out_count=acc, both held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready=0, so no word is accepted in the same cycle as the output handshake.
  - Back-to-back throughput is therefore one word per NCHUNK+2 cycles.
- Latency: word accepted at edge T; out_valid asserted after edge T+NCHUNK, i.e. observed in the cycle following the NCHUNK RUN cycles.
- Width rules:
  - acc is CW bits; it cannot overflow because the maximum value W fits in CW bits.
  - popcnt6 returns 3 bits, zero-extended before the add.
- in_valid while busy: ignored; no data capture.
- out_count is driven from acc only in DONE; it is 0 in other states.

Optional Feature:
- Macro POPCNT_EARLY_EXIT_EN.
- Defined: in RUN, if the remaining chunks are all zero (sreg>>6 == 0 after the current add, or sreg==0 on entry), go directly to DONE.
  - Latency drops to the index of the highest nonzero chunk plus 1 RUN cycles, minimum 1.
  - The count value is unchanged.
- Undefined: RUN always lasts exactly NCHUNK cycles; latency is data-independent.

Decomposition:
- Package popcnt_pkg holds:
  - CHUNK_W=6;
  - the state enum (IDLE, RUN, DONE), 2 bits;
  - a count-width function returning $clog2(w+1).
- Sub-module popcnt6: combinational, 6-bit input, 3-bit output ones count. It is the shared datapath, instantiated once.
- The FSM, shift register and accumulator live in popcnt_seq.

Test Plan:
- Zero word: W=24, in_data=24'h000000, out_ready=1, macro off -> out_count=0, out_valid exactly 4 RUN cycles after accept, single-cycle pulse.
- All ones: in_data=24'hFFFFFF -> out_count=24 (5'b11000); then in_ready=1 the cycle after the output handshake.
- Mixed pattern: in_data=24'hA5A5A5 -> out_count=12; in_data=24'h800001 -> 2.
- Backpressure: in_data=24'h00FF00, out_ready=0 for 3 cycles in DONE, in_valid=1 throughout -> out_valid and out_count=8 stable, in_ready=0, no second capture; out_ready=1 -> IDLE.
- Reset mid-op: assert rst_n=0 in the 2nd RUN cycle -> immediately in_ready=1, out_valid=0, out_count=0, busy=0; a new word after release counts correctly.
- Early exit: in_data=24'h00003F -> with POPCNT_EARLY_EXIT_EN, count 6 after 1 RUN cycle; without it, count 6 after 4 RUN cycles.
